// File: rtl/rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_pkg
//  Description : Shared helpers for the round-robin arbiter. Holds the
//                cyclic pointer-increment function used to advance the
//                priority pointer past the last granted requester.
//  Revision    : 1.0 - initial release
// ============================================================================
package rr_arbiter_pkg;

    // Widest index the helper handles; the pointer is far narrower in practice.
    localparam int c_IDX_W = 32;

    // Increment an index modulo n: n-1 wraps back to 0.
    function automatic logic [c_IDX_W-1:0] wrap_inc(
        input logic [c_IDX_W-1:0] idx,
        input logic [c_IDX_W-1:0] n
    );
        logic [c_IDX_W-1:0] nxt;
        nxt = idx + 32'd1;
        return (nxt == n) ? '0 : nxt;
    endfunction

endpackage : rr_arbiter_pkg
`default_nettype wire

// File: rtl/rr_arbiter_fixed_prio_arb.sv
`default_nettype none
// ============================================================================
//  Module      : fixed_prio_arb
//  Description : LSB-first fixed-priority picker. Returns a one-hot vector
//                marking the lowest set bit of req, or all-zero when no
//                bit is set. Purely combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module fixed_prio_arb #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [WIDTH-1:0] gnt_o
);

    // Two's-complement trick isolates the lowest set bit: req & -req.
    assign gnt_o = req_i & (~req_i + WIDTH'(1));

endmodule : fixed_prio_arb
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter for NUM_REQ requesters. The grant is
//                combinational from req_i and a registered priority pointer;
//                the pointer moves one past the granted index on each clock
//                edge that carries a grant, and holds otherwise.
//                Double-priority-encoder scheme: a picker on requests at or
//                above the pointer wins; otherwise a picker on all requests
//                supplies the wrapped-around winner.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_d;
    logic [PTR_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] prio_mask;
    logic [NUM_REQ-1:0] req_masked;
    logic [NUM_REQ-1:0] gnt_masked;
    logic [NUM_REQ-1:0] gnt_raw;
    logic [NUM_REQ-1:0] gnt;

    // Thermometer mask: keep only requesters whose index is >= ptr.
    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_mask
            assign prio_mask[i] = (PTR_W'(i) >= ptr_q);
        end
    endgenerate

    assign req_masked = req_i & prio_mask;

    fixed_prio_arb #(
        .WIDTH (NUM_REQ)
    ) u_arb_masked (
        .req_i (req_masked),
        .gnt_o (gnt_masked)
    );

    fixed_prio_arb #(
        .WIDTH (NUM_REQ)
    ) u_arb_raw (
        .req_i (req_i),
        .gnt_o (gnt_raw)
    );

    // Select the grant; reset suppresses it immediately, independent of the clock.
    always_comb begin
        gnt = '0;
        if (!rst_i) begin
            gnt = (|gnt_masked) ? gnt_masked : gnt_raw;
        end
    end

    assign gnt_o = gnt;

    // Encode the one-hot grant and compute the next pointer one past it.
    always_comb begin
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                gnt_idx = gnt_idx | PTR_W'(k);
            end
        end
        ptr_d = ptr_q;
        if (|gnt) begin
            ptr_d = PTR_W'(wrap_inc(32'(gnt_idx), 32'(NUM_REQ)));
        end
    end

    // Priority pointer register, cleared asynchronously so requester 0 leads after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: tb/tb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter
//  Description : Self-checking bench for rr_arbiter at NUM_REQ = 4, 2 and 5.
//                Directed steps exercise reset, rotation, wrap/skip, idle
//                hold and asynchronous reset; random steps compare against a
//                cyclic-scan reference model and check fairness/invariants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req4 = '0;
    logic [1:0] req2 = '0;
    logic [4:0] req5 = '0;
    logic [3:0] gnt4;
    logic [1:0] gnt2;
    logic [4:0] gnt5;

    int nassert = 0;
    int nfail   = 0;

    // Reference state per DUT (0: N=4, 1: N=2, 2: N=5).
    int ptr_m  [3];
    int wait_m [3][8];

    always #5 clk = ~clk;

    rr_arbiter #(.NUM_REQ(4)) u_dut4 (.clk_i(clk), .rst_i(rst), .req_i(req4), .gnt_o(gnt4));
    rr_arbiter #(.NUM_REQ(2)) u_dut2 (.clk_i(clk), .rst_i(rst), .req_i(req2), .gnt_o(gnt2));
    rr_arbiter #(.NUM_REQ(5)) u_dut5 (.clk_i(clk), .rst_i(rst), .req_i(req5), .gnt_o(gnt5));

    // Scan from ptr cyclically; first asserted request wins.
    function automatic int ref_idx(input logic [7:0] req, input int ptr, input int n);
        for (int o = 0; o < n; o++) begin
            int k;
            k = (ptr + o) % n;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nassert++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            ptr_m[d] = 0;
            for (int k = 0; k < 8; k++) wait_m[d][k] = 0;
        end
    endtask

    // Compare one DUT against the model, check invariants and fairness, advance model.
    task automatic check_dut(input int id, input int n, input logic [7:0] req,
                             input logic [7:0] gnt, input string tag);
        int         k;
        logic [7:0] exp;
        k   = ref_idx(req, ptr_m[id], n);
        exp = '0;
        if (k >= 0) exp[k] = 1'b1;
        chk({tag, "_model"}, gnt, exp);
        chk({tag, "_onehot0"}, 8'($onehot0(gnt)), 8'd1);
        chk({tag, "_subset"}, gnt & ~req, 8'd0);
        chk({tag, "_busy"}, 8'(gnt != 0), 8'(req != 0));
        for (int j = 0; j < n; j++) begin
            if (req[j] && !gnt[j]) wait_m[id][j]++;
            else                   wait_m[id][j] = 0;
            if (req[j]) begin
                nassert++;
                assert (wait_m[id][j] < n) else begin
                    nfail++;
                    $error("FAIL %s_starve: req %0d waited %0d cycles, limit %0d",
                           tag, j, wait_m[id][j], n - 1);
                end
            end
        end
        if (k >= 0) ptr_m[id] = (k + 1) % n;
    endtask

    task automatic check_all(input string tag);
        check_dut(0, 4, 8'(req4), 8'(gnt4), {tag, "_n4"});
        check_dut(1, 2, 8'(req2), 8'(gnt2), {tag, "_n2"});
        check_dut(2, 5, 8'(req5), 8'(gnt5), {tag, "_n5"});
    endtask

    // One directed cycle on the N=4 arbiter with a literal expected grant.
    task automatic step(input logic [3:0] r, input logic [3:0] exp, input string tag);
        @(negedge clk);
        req4 = r;
        req2 = '0;
        req5 = '0;
        #1;
        chk(tag, 8'(gnt4), 8'(exp));
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        req4 = 4'b1111;
        req2 = 2'b11;
        req5 = 5'b11111;
        model_reset();
        #1;
        chk("rst_gnt4", 8'(gnt4), 8'd0);
        chk("rst_gnt2", 8'(gnt2), 8'd0);
        chk("rst_gnt5", 8'(gnt5), 8'd0);
        @(posedge clk);
        @(negedge clk);
        req4 = '0;
        req2 = '0;
        req5 = '0;
        rst  = 1'b0;
    endtask

    task automatic rnd_cycle(input int c);
        @(negedge clk);
        req4 = 4'($urandom | $urandom);
        req2 = 2'($urandom | $urandom);
        req5 = 5'($urandom | $urandom);
        if ($urandom_range(0, 7) == 0) req4 = '0;
        if ($urandom_range(0, 7) == 0) req5 = '0;
        #1;
        check_all($sformatf("rnd%0d", c));
    endtask

    initial begin
        model_reset();
        do_reset();

        step(4'b0001, 4'b0001, "first_after_rst");

        do_reset();
        step(4'b1111, 4'b0001, "rot0");
        step(4'b1111, 4'b0010, "rot1");
        step(4'b1111, 4'b0100, "rot2");
        step(4'b1111, 4'b1000, "rot3");
        step(4'b1111, 4'b0001, "rot4");

        step(4'b1000, 4'b1000, "grant3");
        step(4'b1010, 4'b0010, "wrap_skip");
        step(4'b1001, 4'b1000, "skip_to3");
        step(4'b1001, 4'b0001, "wrap_to0");

        step(4'b0010, 4'b0010, "pre_idle");
        step(4'b0000, 4'b0000, "idle0");
        step(4'b0000, 4'b0000, "idle1");
        step(4'b0000, 4'b0000, "idle2");
        step(4'b0011, 4'b0001, "post_idle");

        // Bring ptr to 2, then pulse reset between edges.
        step(4'b0010, 4'b0010, "set_ptr2");
        step(4'b0100, 4'b0100, "ptr2_grant");
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_drop", 8'(gnt4), 8'd0);
        rst  = 1'b0;
        req4 = 4'b1111;
        #1;
        chk("after_async_rst", 8'(gnt4), 8'b0001);
        check_all("after_async_rst");

        for (int c = 0; c < 60; c++) rnd_cycle(c);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule : tb_rr_arbiter
`default_nettype wire
